// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART link constants and the receiver state encoding.
// Rev    : 1.0
// ============================================================================
package uart_pkg;

    localparam int UART_CLK_FREQ     = 16_000_000;
    localparam int UART_BAUD_RATE    = 1_000_000;
    localparam int UART_DATA_LENGTH  = 8;
    localparam int UART_PARITY_MODE  = 0;
    localparam int UART_CLKS_PER_BIT = UART_CLK_FREQ / UART_BAUD_RATE + 1;
    localparam int UART_HALF_BIT     = UART_CLKS_PER_BIT / 2;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// Module : uart_sync2
// Brief  : Two-flop synchronizer for an asynchronous single-bit input.
// Rev    : 1.0
// ============================================================================
module uart_sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : uart_sync2
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module : uart_rx
// Brief  : Oversampling UART receiver (start, data LSB first, parity, stop)
//          with a valid/ready output handshake and error/overrun flags.
// Rev    : 1.0
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int   DATA_LENGTH  = UART_DATA_LENGTH,
    parameter int   CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter logic PARITY_MODE  = 1'(UART_PARITY_MODE)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_sig,
    output logic [DATA_LENGTH-1:0] data,
    output logic                   valid,
    input  logic                   ready,
    output logic                   parity_err,
    output logic                   frame_err,
    output logic                   overrun
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int c_CNT_W  = $clog2(CLKS_PER_BIT) + 1;
    localparam int c_IDX_W  = $clog2(DATA_LENGTH + 1);

    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(HALF_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(DATA_LENGTH - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE   = c_IDX_W'(1);

    localparam logic [2:0] c_ST_IDLE   = RX_IDLE;
    localparam logic [2:0] c_ST_START  = RX_START;
    localparam logic [2:0] c_ST_DATA   = RX_DATA;
    localparam logic [2:0] c_ST_PARITY = RX_PARITY;
    localparam logic [2:0] c_ST_STOP   = RX_STOP;
    localparam logic [2:0] c_ST_BREAK  = RX_BREAK;

    logic                   w_s;
    logic                   w_fall;
    logic                   w_bit_end;
    logic                   r_s_prev;
    logic [1:0]             r_settle;
    logic                   r_armed;
    logic [2:0]             r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_IDX_W-1:0]     r_idx;
    logic [DATA_LENGTH-1:0] r_shreg;
    logic                   r_parity;
    logic                   r_perr;

    uart_sync2 #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx_sig),
        .o_q   (w_s)
    );

    assign w_fall    = r_s_prev & ~w_s;
    assign w_bit_end = (r_cnt == c_BIT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            r_state    <= c_ST_IDLE;
            r_s_prev   <= 1'b1;
            r_settle   <= 2'b00;
            r_armed    <= 1'b0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shreg    <= '0;
            r_parity   <= 1'b0;
            r_perr     <= 1'b0;
        end else begin
            r_s_prev <= w_s;
            // The synchronizer's reset-value ones are not a real idle line;
            // arming waits until they have been flushed out.
            r_settle <= {r_settle[0], 1'b1};
            if (w_s && r_settle[1]) begin
                r_armed <= 1'b1;
            end
            overrun <= 1'b0;
            r_cnt   <= r_cnt + c_CNT_ONE;
            if (valid && ready) begin
                valid <= 1'b0;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (r_armed && w_fall) begin
                        r_state  <= c_ST_START;
                        r_cnt    <= '0;
                        r_parity <= PARITY_MODE;
                    end
                end
                c_ST_START: begin
                    if (r_cnt == c_HALF_LAST) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= w_s ? c_ST_IDLE : c_ST_DATA;
                    end
                end
                c_ST_DATA: begin
                    if (w_bit_end) begin
                        r_cnt    <= '0;
                        r_shreg  <= {w_s, r_shreg[DATA_LENGTH-1:1]};
                        r_parity <= r_parity ^ w_s;
                        if (r_idx == c_IDX_LAST) begin
                            r_state <= c_ST_PARITY;
                        end else begin
                            r_idx <= r_idx + c_IDX_ONE;
                        end
                    end
                end
                c_ST_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_perr  <= (w_s != r_parity);
                        r_state <= c_ST_STOP;
                    end
                end
                c_ST_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        // A coincident accept frees the slot for the new byte.
                        if (!valid || ready) begin
                            data       <= r_shreg;
                            parity_err <= r_perr;
                            frame_err  <= ~w_s;
                            valid      <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                        r_state <= w_s ? c_ST_IDLE : c_ST_BREAK;
                    end
                end
                c_ST_BREAK: begin
                    if (w_s) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_rx
// Brief  : Self-checking bench for uart_rx: vector table, hand sequences and
//          randomized frames against a frame-level reference model.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int   CPB = 17;
    localparam int   DL  = 8;
    localparam logic PM  = 1'b0;

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic          rx_sig = 1'b1;
    logic          ready  = 1'b0;
    logic [DL-1:0] data;
    logic          valid;
    logic          parity_err;
    logic          frame_err;
    logic          overrun;

    uart_rx #(
        .DATA_LENGTH  (DL),
        .CLKS_PER_BIT (CPB),
        .PARITY_MODE  (PM)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_sig     (rx_sig),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: records every rising edge of valid and what it presented.
    int            rise_cnt = 0;
    int            rise_cyc = 0;
    int            hi_len   = 0;
    int            ovr_cnt  = 0;
    logic [DL-1:0] rise_data = '0;
    logic          rise_perr = 1'b0;
    logic          rise_ferr = 1'b0;
    logic          prev_valid = 1'b0;

    always @(negedge clk) begin
        if (overrun === 1'b1) ovr_cnt++;
        if (valid === 1'b1 && !prev_valid) begin
            rise_cnt++;
            rise_cyc  = cyc;
            hi_len    = 1;
            rise_data = data;
            rise_perr = parity_err;
            rise_ferr = frame_err;
        end else if (valid === 1'b1) begin
            hi_len++;
        end
        prev_valid = (valid === 1'b1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic b, input int n);
        rx_sig = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DL-1:0] d, input logic pbit, input logic stop, input int idle);
        drive(1'b0, CPB);
        for (int i = 0; i < DL; i++) drive(d[i], CPB);
        drive(pbit, CPB);
        drive(stop, CPB);
        if (!stop) drive(1'b0, 40);
        drive(1'b1, idle);
    endtask

    // Reference: the parity bit a correct transmitter would send.
    function automatic logic good_par(input logic [DL-1:0] d);
        return PM ^ (^d);
    endfunction

    typedef struct {
        logic [DL-1:0] d;
        logic          pbit;
        logic          stop;
        logic [DL-1:0] exp_d;
        logic          exp_perr;
        logic          exp_ferr;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int            r0;
        int            o0;
        int            start_cyc;
        int            lat;
        logic [DL-1:0] rd;
        logic          pb;
        logic          st;

        tbl[0] = '{d: 8'hA5, pbit: 1'b0, stop: 1'b1, exp_d: 8'hA5, exp_perr: 1'b0, exp_ferr: 1'b0};
        tbl[1] = '{d: 8'h01, pbit: 1'b0, stop: 1'b1, exp_d: 8'h01, exp_perr: 1'b1, exp_ferr: 1'b0};
        tbl[2] = '{d: 8'h3C, pbit: 1'b0, stop: 1'b0, exp_d: 8'h3C, exp_perr: 1'b0, exp_ferr: 1'b1};
        tbl[3] = '{d: 8'h5A, pbit: 1'b0, stop: 1'b1, exp_d: 8'h5A, exp_perr: 1'b0, exp_ferr: 1'b0};
        tbl[4] = '{d: 8'h00, pbit: 1'b1, stop: 1'b1, exp_d: 8'h00, exp_perr: 1'b1, exp_ferr: 1'b0};
        tbl[5] = '{d: 8'h80, pbit: 1'b1, stop: 1'b1, exp_d: 8'h80, exp_perr: 1'b0, exp_ferr: 1'b0};

        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", {31'b0, valid}, 32'd0);
        check("reset_data", {24'b0, data}, 32'd0);
        check("reset_perr", {31'b0, parity_err}, 32'd0);
        check("reset_ferr", {31'b0, frame_err}, 32'd0);
        check("reset_overrun", {31'b0, overrun}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        drive(1'b1, 10);

        // Nominal frame: latency and a single-cycle valid with ready held high.
        ready = 1'b1;
        r0 = rise_cnt;
        start_cyc = cyc;
        send_frame(8'hA5, 1'b0, 1'b1, 20);
        check("nom_rises", rise_cnt - r0, 32'd1);
        check("nom_data", {24'b0, rise_data}, 32'hA5);
        check("nom_hi_len", hi_len, 32'd1);
        lat = rise_cyc - start_cyc;
        checks++;
        if (lat < 180 || lat > 182) begin
            errors++;
            $display("FAIL nom_latency: got %0d expected 181 +/-1", lat);
        end

        for (int k = 0; k < 6; k++) begin
            r0 = rise_cnt;
            send_frame(tbl[k].d, tbl[k].pbit, tbl[k].stop, 20);
            check($sformatf("tbl%0d_rises", k), rise_cnt - r0, 32'd1);
            check($sformatf("tbl%0d_data", k), {24'b0, rise_data}, {24'b0, tbl[k].exp_d});
            check($sformatf("tbl%0d_perr", k), {31'b0, rise_perr}, {31'b0, tbl[k].exp_perr});
            check($sformatf("tbl%0d_ferr", k), {31'b0, rise_ferr}, {31'b0, tbl[k].exp_ferr});
        end

        // Short low glitch must be rejected.
        r0 = rise_cnt;
        drive(1'b0, 5);
        drive(1'b1, 30);
        check("glitch_rises", rise_cnt - r0, 32'd0);
        check("glitch_valid", {31'b0, valid}, 32'd0);
        r0 = rise_cnt;
        send_frame(8'hFF, 1'b0, 1'b1, 20);
        check("post_glitch_rises", rise_cnt - r0, 32'd1);
        check("post_glitch_data", {24'b0, rise_data}, 32'hFF);
        check("post_glitch_perr", {31'b0, rise_perr}, 32'd0);

        // Overrun: second frame arrives while the first is still unaccepted.
        ready = 1'b0;
        r0 = rise_cnt;
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b0, 1'b1, 2);
        send_frame(8'h22, 1'b0, 1'b1, 5);
        check("ovr_pulses", ovr_cnt - o0, 32'd1);
        check("ovr_rises", rise_cnt - r0, 32'd1);
        check("ovr_valid_held", {31'b0, valid}, 32'd1);
        check("ovr_data_held", {24'b0, data}, 32'h11);
        check("ovr_perr_held", {31'b0, parity_err}, 32'd0);
        ready = 1'b1;
        @(posedge clk);
        #1;
        check("ovr_valid_drop", {31'b0, valid}, 32'd0);
        drive(1'b1, 10);

        // Reset during data bit 3 of 0x77 with the line held low across release.
        drive(1'b0, CPB);
        drive(1'b1, CPB);
        drive(1'b1, CPB);
        drive(1'b1, CPB);
        drive(1'b0, 8);
        reset = 1'b0;
        #1;
        check("midrst_valid", {31'b0, valid}, 32'd0);
        check("midrst_data", {24'b0, data}, 32'd0);
        r0 = rise_cnt;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        drive(1'b0, 25);
        drive(1'b1, 30);
        check("midrst_no_spurious", rise_cnt - r0, 32'd0);
        send_frame(8'h42, 1'b0, 1'b1, 20);
        check("midrst_rises", rise_cnt - r0, 32'd1);
        check("midrst_data_42", {24'b0, rise_data}, 32'h42);

        // Randomized frames against the frame-level model.
        for (int k = 0; k < 16; k++) begin
            rd = DL'($urandom);
            pb = good_par(rd) ^ ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 7) != 0);
            r0 = rise_cnt;
            send_frame(rd, pb, st, 5 + $urandom_range(0, 20));
            check($sformatf("rnd%0d_rises", k), rise_cnt - r0, 32'd1);
            check($sformatf("rnd%0d_data", k), {24'b0, rise_data}, {24'b0, rd});
            check($sformatf("rnd%0d_perr", k), {31'b0, rise_perr}, {31'b0, pb != good_par(rd)});
            check($sformatf("rnd%0d_ferr", k), {31'b0, rise_ferr}, {31'b0, ~st});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver for the Sigma Delta DAQ. It is the receive end of the same serial link that UartTx drives.
- Frame format: 1 start bit (0), UART_DATA_LENGTH data bits LSB first, 1 parity bit, 1 stop bit (1).
- It oversamples the serial line on the system clock, deserializes each frame, checks parity and stop bit, and presents the byte on a valid/ready handshake to the downstream command decoder.

Parameters:
- DATA_LENGTH, UART_DATA_LENGTH (8): data bits per frame.
- CLKS_PER_BIT, UART_CLK_FREQ/UART_BAUD_RATE + 1: clock cycles per bit. This equals the transmitter's bit period. Must be >= 4.
- HALF_BIT, CLKS_PER_BIT/2: offset from the start-bit falling edge to the mid-bit sample point.
- PARITY_MODE, UART_PARITY_MODE (0): parity seed. Expected parity = PARITY_MODE XOR (XOR-reduce of the data bits).

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset.
- rx_sig, in, 1: asynchronous serial line, idle high.
- data, out, DATA_LENGTH: received byte, stable while valid=1.
- valid, out, 1: byte available.
- ready, in, 1: consumer accepts the byte when valid && ready.
- parity_err, out, 1: parity mismatch for the presented byte, qualified by valid.
- frame_err, out, 1: stop bit sampled 0 for the presented byte, qualified by valid.
- overrun, out, 1: one-cycle pulse when a frame completes while valid is still 1.

Behaviour:
- Interface decision: one clock `clk`; `reset` is asynchronous and active-low.
- Reset values: data=0, valid=0, parity_err=0, frame_err=0, overrun=0, state=IDLE, both synchronizer flops=1, armed=0.
- rx_sig passes through a 2-flop synchronizer. All decisions use the synchronized value `s`. Edge detection compares `s` with the previous `s`.
- armed is set once `s`=1 is seen. It prevents a line held low across reset release from being taken as a start bit.
- One bit-cycle counter, width $clog2(CLKS_PER_BIT)+1, reloaded to 0 on every state change. One data index counter and a running parity register.
- FSM transitions:
  - IDLE: when armed and a falling edge on `s` occurs -> START, counter=0, parity=PARITY_MODE.
  - START: at counter==HALF_BIT-1, sample `s`. If 1 (glitch) -> IDLE, nothing reported. If 0 -> DATA, index=0, counter=0.
  - DATA: at counter==CLKS_PER_BIT-1, shift `s` into shreg[index] and XOR it into parity. At index==DATA_LENGTH-1 -> PARITY, otherwise index+1.
  - PARITY: at counter==CLKS_PER_BIT-1, perr = (`s` != parity). -> STOP.
  - STOP: at counter==CLKS_PER_BIT-1, ferr = ~`s`, then deliver. -> IDLE if `s`=1, otherwise -> BREAK.
  - BREAK: wait for `s`=1, then -> IDLE. No start detection until then.
- Deliver, registered, effective the cycle after the stop sample:
  - If valid=0 or (valid && ready) in that same cycle: load data, parity_err and frame_err from the new frame, and set valid=1.
  - Otherwise keep the old byte and flags, drop the new byte, and pulse overrun for 1 cycle.
- Handshake:
  - valid falls the cycle after valid && ready, unless a new deliver coincides, in which case valid stays 1 with the new data.
  - data and the flags are held constant while valid=1 and ready=0.
- Latency: rx_sig falling edge to valid=1 is 2 + HALF_BIT + (DATA_LENGTH+2)*CLKS_PER_BIT + 1 cycles, ±1 for synchronizer phase.
- Sample points sit at mid-bit, giving ±HALF_BIT/(DATA_LENGTH+2) cycles of per-bit period tolerance.
- Reset asserted mid-frame: everything returns to reset values immediately. The partial frame is discarded.

Decomposition:
- Add to the UART package (UartParam.svh): the rx state enum {IDLE, START, DATA, PARITY, STOP, BREAK} and CLKS_PER_BIT/HALF_BIT derived constants, shared with the transmitter.
- One natural sub-module: uart_sync2, a 2-flop synchronizer with parameterized reset value 1, reusable for other asynchronous inputs.

Test Plan:
Bench config: CLKS_PER_BIT=17, DATA_LENGTH=8, PARITY_MODE=0.
1. Nominal: send 0xA5 with parity 0 and stop 1 -> valid rises once, data=0xA5, parity_err=0, frame_err=0. With ready=1, valid lasts 1 cycle. Also check latency per formula.
2. Parity error: send 0x01 with parity bit 0 (expected 1) -> data=0x01, parity_err=1, frame_err=0.
3. Framing/break: send 0x3C with stop bit 0, then hold the line low for 40 cycles, then high -> frame_err=1. No second valid during the low hold. The next correct frame 0x5A is received cleanly.
4. Glitch: pulse rx_sig low for 5 cycles -> returns to IDLE, no valid, no flags. A following 0xFF frame is received correctly.
5. Overrun: ready=0, send 0x11 then 0x22 back-to-back -> data stays 0x11, one overrun pulse at the second stop. Raise ready -> 0x11 is accepted, then valid=0.
6. Reset mid-frame: assert reset during DATA bit 3 of 0x77, hold the line low across release, then idle high and send 0x42 -> no spurious byte; data=0x42 is received.
